qr_result_serializer: RTL
=========================

Name: qr_result_serializer

Overview:
- Sits directly downstream of the QR engine and consumes its per-RE result (o_rd_vld, o_last_data, o_r[319:0], o_y_hat[159:0]).
- Buffers whole 480-bit RE results in a small FIFO, because the engine cannot be back-pressured.
- Serializes each buffered RE into 6 beats of 80 bits on a valid/ready stream for the detector/writeback path.
- Flags overflow and group-framing errors.

Parameters:
- DEPTH, 4, number of RE result entries buffered (power of 2, >=2).
- GROUP, 10, REs per group; the engine's last flag is expected on RE GROUP-1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rd_vld  in  1  engine result valid, one RE per asserted cycle; may be asserted back-to-back.
- i_last_data  in  1  engine last-RE-of-group flag; qualified by i_rd_vld.
- i_r  in  320  R matrix result.
- i_y_hat  in  160  y_hat result.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  80  output beat.
- o_sop  out  1  first beat (beat 0) of an RE.
- o_last  out  1  beat 5 of an RE tagged last.
- o_re_idx  out  4  group index (0..GROUP-1) of the RE currently on o_data.
- o_occupancy  out  3  entries held, 0..DEPTH; width is clog2(DEPTH)+1.
- o_overflow  out  1  sticky: an RE was dropped.
- o_frame_err  out  1  sticky: group framing violated.

Behaviour:
- Reset: already decided, one clock and asynchronous active-low reset. Every output, pointer, counter and sticky flag clears to 0. Buffer contents are don't-care.

Storage:
- Each entry holds {last_tag, re_idx[3:0], y_hat[159:0], r[319:0]}.
- Write pointer, read pointer and occupancy counter.

Write:
- Taken on i_rd_vld when occupancy<DEPTH, or when occupancy==DEPTH and a final-beat pop (see Read) happens in the same cycle.
- Otherwise the RE is dropped: o_overflow sets, and the write pointer and group counter do not advance.

Group counter:
- Counts accepted writes and provides re_idx.
- Resets to 0 after a write tagged last.
- An accepted write with i_last_data=1 and counter!=GROUP-1 sets o_frame_err and resets the counter to 0.
- An accepted write at counter==GROUP-1 with i_last_data=0 sets o_frame_err and wraps the counter to 0.

Read FSM:
- States: IDLE, SEND.
- IDLE: o_valid=0. Go to SEND when occupancy>0, evaluated on registered occupancy.
- SEND: o_valid=1, beat counter b in 0..5.
- Beat mapping from the head entry, fixed order:
  - b0 = r[79:0], b1 = r[159:80], b2 = r[239:160], b3 = r[319:240]
  - b4 = y_hat[79:0], b5 = y_hat[159:80]
- Flags: o_sop = (b==0). o_last = (b==5 && last_tag). o_re_idx = the head entry's re_idx.
- Handshake:
  - A beat transfers on o_valid && i_ready; b then increments.
  - When valid and not ready, o_data/o_sop/o_last/o_re_idx hold stable.
- On transfer of b5: pop the entry and reset b to 0. Stay in SEND if occupancy after the pop/push >0, else go to IDLE.
- Latency: an RE written at edge t into an empty buffer gives o_valid=1 with beat 0 after edge t+1. With i_ready=1, the 6 beats take cycles t+1..t+6.
- Throughput: 1 RE per 6 cycles, with no bubble between consecutive REs.

Simultaneous events:
- Push and pop in the same cycle leave occupancy unchanged.
- Full plus pop plus push: the push is accepted and there is no overflow.
- Pointers wrap modulo DEPTH.

Reset mid-operation:
- An in-flight beat is abandoned and o_valid drops immediately (asynchronous).
- Buffered REs are lost and the sticky flags clear.

Test Plan:
- Single RE:
  - Stimulus: i_r = 320'h...0003_0002_0001 pattern (slice k = {20{4'hk}}), i_y_hat slices 4/5, i_ready=1.
  - Response: six beats on consecutive cycles starting 1 cycle after write. o_data = {20{4'h0}}..{20{4'h5}}. o_sop only on beat 0, o_last=0, o_re_idx=0, then o_valid=0 and o_occupancy=0.
- Backpressure:
  - Stimulus: i_ready pattern 1,0,0,1,0,1,1,1,1.
  - Response: the beat index advances only on ready cycles, o_data is stable across stalls, and all 6 beats arrive in order.
- Overflow:
  - Stimulus: 5 REs back-to-back with i_ready=0.
  - Response: o_occupancy=4, o_overflow=1. After raising ready, exactly REs 0..3 are emitted (24 beats) and RE 4 is absent.
- Full group:
  - Stimulus: 10 REs spaced 20 cycles apart, i_last_data on the 10th, i_ready=1.
  - Response: o_re_idx runs 0..9, o_last asserts only on beat 5 of RE 9, o_frame_err=0. An 11th RE carries o_re_idx=0.
- Framing error:
  - Stimulus: i_last_data on the 3rd RE.
  - Response: o_frame_err=1 and stays 1. The next RE has o_re_idx=0.
- Full+pop+push:
  - Stimulus: fill 4 REs, then push a new RE on the exact cycle beat 5 of the head transfers.
  - Response: o_overflow=0, o_occupancy stays 4.
- Reset mid-stream:
  - Stimulus: assert i_rst_n=0 during beat 2.
  - Response: o_valid, o_occupancy and flags are 0 immediately. After release, a new RE serializes starting at beat 0 with o_re_idx=0.

Source files
------------

// File: rtl/qr_result_serializer.sv
// rtl/qr_result_serializer.sv - buffers 480-bit QR engine RE results and serializes each one as six 80-bit beats
module qr_result_serializer #(
  parameter int DEPTH = 4,
  parameter int GROUP = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rd_vld,
  input  logic                    i_last_data,
  input  logic [319:0]            i_r,
  input  logic [159:0]            i_y_hat,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [79:0]             o_data,
  output logic                    o_sop,
  output logic                    o_last,
  output logic [3:0]              o_re_idx,
  output logic [$clog2(DEPTH):0]  o_occupancy,
  output logic                    o_overflow,
  output logic                    o_frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 485;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [3:0]  GLAST = 4'(GROUP - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [2:0]      beat_q, beat_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [3:0]      grp_q, grp_d;
  logic            overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic            push, pop;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic [79:0]     beat_data;

  // Entry layout: {last_tag, re_idx[3:0], y_hat[159:0], r[319:0]}
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    case (beat_q)
      3'd0:    beat_data = head[79:0];
      3'd1:    beat_data = head[159:80];
      3'd2:    beat_data = head[239:160];
      3'd3:    beat_data = head[319:240];
      3'd4:    beat_data = head[399:320];
      3'd5:    beat_data = head[479:400];
      default: beat_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    grp_d       = grp_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    pop         = (state_q == SEND) && i_ready && (beat_q == 3'd5);
    // A full buffer still accepts when the head leaves on this same edge.
    push        = i_rd_vld && ((occ_q != FULL) || pop);

    if (i_rd_vld && !push) overflow_d = 1'b1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (i_last_data) begin
        grp_d = '0;
        if (grp_q != GLAST) frame_err_d = 1'b1;
      end else if (grp_q == GLAST) begin
        grp_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        grp_d = grp_q + 4'd1;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);

    if (state_q == IDLE) begin
      if (occ_q != '0) state_d = SEND;
    end else if (i_ready) begin
      if (beat_q == 3'd5) begin
        beat_d = 3'd0;
        if (occ_d == '0) state_d = IDLE;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      grp_q       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      grp_q       <= grp_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_last_data, grp_q, i_y_hat, i_r};
  end

  // Beat outputs are gated so nothing from stale buffer contents shows while idle or in reset.
  assign o_valid     = (state_q == SEND);
  assign o_data      = o_valid ? beat_data : '0;
  assign o_sop       = o_valid && (beat_q == 3'd0);
  assign o_last      = o_valid && (beat_q == 3'd5) && head[484];
  assign o_re_idx    = o_valid ? head[483:480] : '0;
  assign o_occupancy = occ_q;
  assign o_overflow  = overflow_q;
  assign o_frame_err = frame_err_q;

endmodule
